// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the dual-clock FIFO: drains the read port into a 2-entry
// buffer and presents a valid/ready stream framed into fixed-length bursts.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  burst_done,
  output logic [7:0]            beat_idx
);

  localparam logic [7:0] LAST_IDX = 8'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic [1:0]            occ;
  logic                  inflight;
  logic                  pop;
  logic                  is_last;
  logic [2:0]            pending;

  assign m_valid = (occ != 2'd0);
  assign m_data  = head;
  assign is_last = (beat_idx == LAST_IDX);
  assign m_last  = m_valid && is_last;
  assign pop     = m_valid && m_ready;

  // A read is issued only if its word is guaranteed a free slot when it lands.
  always_comb begin
    pending    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    fifo_rd_en = rst_n && !fifo_empty && (pending < 3'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      case ({inflight, pop})
        2'b01: begin
          if (occ == 2'd2) head <= tail;
          occ <= occ - 2'd1;
        end
        2'b10: begin
          if (occ == 2'd0) head <= fifo_rd_data;
          else             tail <= fifo_rd_data;
          if (occ != 2'd2) occ <= occ + 2'd1;
        end
        // Capture with pop: occupancy unchanged, tail advances to head.
        2'b11: begin
          if (occ == 2'd2) begin
            head <= tail;
            tail <= fifo_rd_data;
          end else begin
            head <= fifo_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_idx   <= '0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= pop && is_last;
      if (pop) beat_idx <= is_last ? '0 : beat_idx + 8'd1;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO read port, per-cycle table for the
// startup latency, and a scoreboard for streaming, stall, gap, random and reset cases.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          burst_done;
  logic [7:0]    beat_idx;

  fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .burst_done(burst_done), .beat_idx(beat_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ready;
    logic       rd_en;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic [7:0] beat;
    logic       done;
  } vec_t;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  logic          rd_smp;
  int            outstanding;
  int            exp_beat;
  logic          exp_done;
  logic          stall_v;
  logic [DW-1:0] stall_d;
  logic [DW-1:0] last_word;
  int            n_beats;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic reset_on();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_done", 32'(burst_done), 32'd0);
    chk("rst_beat", 32'(beat_idx), 32'd0);
    fq.delete();
    exp_q.delete();
    outstanding = 0;
    exp_beat    = 0;
    exp_done    = 1'b0;
    stall_v     = 1'b0;
    last_word   = '0;
    n_beats     = 0;
  endtask

  task automatic reset_off();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic cyc_start(input logic ready);
    @(negedge clk);
    fifo_empty = (fq.size() == 0);
    m_ready    = ready;
    #1;
    rd_smp = fifo_rd_en;
  endtask

  // Registered FIFO read port: the word appears the cycle after an accepted read.
  task automatic cyc_end();
    @(posedge clk);
    if (rd_smp && fq.size() > 0) fifo_rd_data <= fq.pop_front();
  endtask

  task automatic run_cycle(input logic ready);
    logic          p;
    logic          el;
    logic [DW-1:0] e;
    cyc_start(ready);
    p  = m_valid && m_ready;
    el = (exp_beat == BL - 1);
    chk("burst_done", 32'(burst_done), 32'(exp_done));
    chk("beat_idx", 32'(beat_idx), 32'(exp_beat));
    chk("m_last", 32'(m_last), 32'(m_valid && el));
    if (stall_v) begin
      chk("hold_valid", 32'(m_valid), 32'd1);
      chk("hold_data", 32'(m_data), 32'(stall_d));
    end
    chk("rd_en", 32'(fifo_rd_en), 32'(!fifo_empty && (outstanding - int'(p)) < 2));
    if (p) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL extra_beat: got beat %02h, required no beat (t=%0t)", m_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("m_data", 32'(m_data), 32'(e));
      end
      if (m_last) last_word = m_data;
      n_beats++;
      exp_beat = (exp_beat + 1) % BL;
    end
    outstanding = outstanding - int'(p) + int'(fifo_rd_en);
    chk("occ_bound", 32'(outstanding <= 2), 32'd1);
    exp_done = p && el;
    stall_v  = m_valid && !m_ready;
    stall_d  = m_data;
    cyc_end();
  endtask

  initial begin
    vec_t tbl[7];
    int   n_rd;
    int   sent;
    int   cyc;

    tbl[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 8'd0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 8'd1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 8'd2, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'd3, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'd3, 1'b0};

    // Startup latency from reset with three words waiting.
    reset_on();
    push(8'h11); push(8'h22); push(8'h33);
    fifo_empty = 1'b0;
    #1 chk("rd_en_in_reset", 32'(fifo_rd_en), 32'd0);
    reset_off();
    foreach (tbl[i]) begin
      cyc_start(tbl[i].ready);
      chk($sformatf("tbl%0d_rd_en", i), 32'(fifo_rd_en), 32'(tbl[i].rd_en));
      chk($sformatf("tbl%0d_valid", i), 32'(m_valid), 32'(tbl[i].valid));
      if (tbl[i].valid) chk($sformatf("tbl%0d_data", i), 32'(m_data), 32'(tbl[i].data));
      chk($sformatf("tbl%0d_last", i), 32'(m_last), 32'(tbl[i].last));
      chk($sformatf("tbl%0d_beat", i), 32'(beat_idx), 32'(tbl[i].beat));
      chk($sformatf("tbl%0d_done", i), 32'(burst_done), 32'(tbl[i].done));
      cyc_end();
    end

    // Two full bursts back to back.
    reset_on();
    for (int i = 0; i < 8; i++) push(8'(i));
    reset_off();
    repeat (12) run_cycle(1'b1);
    chk("burst_last_word", 32'(last_word), 32'h07);
    chk("burst_beats", 32'(n_beats), 32'd8);

    // Backpressure: only two reads may be outstanding.
    reset_on();
    for (int i = 0; i < 10; i++) push(8'(i));
    reset_off();
    n_rd = 0;
    for (int i = 0; i < 8; i++) begin
      run_cycle(1'b0);
      n_rd += int'(rd_smp);
    end
    chk("stall_reads", 32'(n_rd), 32'd2);
    chk("stall_valid", 32'(m_valid), 32'd1);
    chk("stall_data", 32'(m_data), 32'h00);
    repeat (16) run_cycle(1'b1);
    chk("stall_drain", 32'(exp_q.size()), 32'd0);
    chk("stall_beats", 32'(n_beats), 32'd10);

    // FIFO runs dry mid-burst and resumes.
    reset_on();
    push(8'hA0); push(8'hA1);
    reset_off();
    repeat (6) run_cycle(1'b1);
    chk("gap_beat", 32'(beat_idx), 32'd2);
    for (int i = 0; i < 5; i++) begin
      run_cycle(1'b1);
      chk("gap_valid", 32'(m_valid), 32'd0);
    end
    push(8'hB0); push(8'hB1); push(8'hB2); push(8'hB3);
    repeat (8) run_cycle(1'b1);
    chk("gap_last_word", 32'(last_word), 32'hB1);
    chk("gap_drain", 32'(exp_q.size()), 32'd0);

    // Random backpressure and random refill.
    reset_on();
    reset_off();
    sent = 0;
    cyc  = 0;
    while ((sent < 1000 || exp_q.size() > 0) && cyc < 20000) begin
      if (sent < 1000 && $urandom_range(0, 2) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 3)) && sent < 1000; k++) begin
          push(8'($urandom));
          sent++;
        end
      end
      run_cycle(1'($urandom_range(0, 1)));
      cyc++;
    end
    chk("rand_drain", 32'(exp_q.size()), 32'd0);
    chk("rand_beats", 32'(n_beats), 32'd1000);

    // Reset with a full buffer; only post-reset words may appear afterwards.
    reset_on();
    for (int i = 0; i < 10; i++) push(8'(8'h40 + i));
    reset_off();
    repeat (5) run_cycle(1'b0);
    chk("pre_rst_valid", 32'(m_valid), 32'd1);
    reset_on();
    push(8'h90); push(8'h91); push(8'h92);
    reset_off();
    repeat (10) run_cycle(1'b1);
    chk("post_rst_drain", 32'(exp_q.size()), 32'd0);
    chk("post_rst_beats", 32'(n_beats), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
